// File: rtl/instruction_fetch.sv
// Instruction fetch front end: PC, one outstanding fetch and a
// small instruction queue feeding the decoder.
module instruction_fetch #(
  parameter int          IQ_WIDTH = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic [31:0] clear_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data,
  input  logic        dec_ready,
  output logic        to_dec,
  output logic [31:0] to_dec_pc,
  output logic [31:0] to_dec_inst
);

  localparam int DEPTH = 1 << IQ_WIDTH;
  localparam logic [IQ_WIDTH:0] CNT_ONE = {{IQ_WIDTH{1'b0}}, 1'b1};
  localparam logic [IQ_WIDTH-1:0] PTR_ONE = CNT_ONE[IQ_WIDTH-1:0];

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } state_t;

  state_t state, state_d;

  logic [31:0] pc, pc_d;
  logic        req_d;
  logic [31:0] addr_d;

  logic [IQ_WIDTH-1:0] head, head_d;
  logic [IQ_WIDTH-1:0] tail, tail_d;
  logic [IQ_WIDTH:0]   count, count_d;

  logic [31:0] q_pc   [DEPTH];
  logic [31:0] q_inst [DEPTH];

  logic push;
  logic pop;
  logic full;

  // count never exceeds DEPTH, so its top bit alone marks full
  assign full        = count[IQ_WIDTH];
  assign to_dec      = (count != '0);
  assign to_dec_pc   = q_pc[head];
  assign to_dec_inst = q_inst[head];

  always_comb begin
    state_d = state;
    pc_d    = pc;
    req_d   = mem_req;
    addr_d  = mem_addr;
    push    = 1'b0;
    head_d  = head;
    tail_d  = tail;
    count_d = count;
    pop     = to_dec && dec_ready && !clear;

    case (state)
      IDLE: begin
        if (clear) begin
          pc_d = clear_pc;
        end else if (!full) begin
          req_d   = 1'b1;
          addr_d  = pc;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (clear) begin
          pc_d = clear_pc;
          if (mem_done) begin
            req_d   = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = DROP;
          end
        end else if (mem_done) begin
          push    = 1'b1;
          pc_d    = pc + 32'd4;
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      DROP: begin
        if (clear) begin
          pc_d = clear_pc;
        end
        if (mem_done) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop) begin
        head_d = head + PTR_ONE;
      end
      if (push) begin
        tail_d = tail + PTR_ONE;
      end
      unique case ({push, pop})
        2'b10:   count_d = count + CNT_ONE;
        2'b01:   count_d = count - CNT_ONE;
        default: count_d = count;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (rdy_in) begin
      state    <= state_d;
      pc       <= pc_d;
      mem_req  <= req_d;
      mem_addr <= addr_d;
      head     <= head_d;
      tail     <= tail_d;
      count    <= count_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in && push) begin
      q_pc[tail]   <= pc;
      q_inst[tail] <= mem_data;
    end
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Front end of the out-of-order core: holds the PC and issues word fetches to the memory/icache port.
- Buffers fetched words with their PCs in a small instruction queue.
- Presents one instruction per cycle to the decoder through a valid/ready handshake; the decoder's stall signal is the ready.
- No branch prediction: next PC is always PC+4. The ROB redirects via clear/clear_pc, which flushes the queue and discards any in-flight fetch.

Parameters:
- IQ_WIDTH, 2, log2 of instruction-queue depth (depth = 4)
- RESET_PC, 32'h0, PC loaded on reset

Ports:
- clk_in  input  1  clock, rising edge
- rst_in  input  1  asynchronous reset, active-high
- rdy_in  input  1  global enable; when low, all state frozen (outputs hold)
- clear  input  1  ROB flush/redirect request, one-cycle pulse
- clear_pc  input  32  redirect target, sampled when clear=1; bits [1:0] are 0 by contract
- mem_req  output  1  fetch request, held until mem_done
- mem_addr  output  32  fetch address, stable while mem_req=1
- mem_done  input  1  one-cycle pulse, mem_data valid this cycle
- mem_data  input  32  fetched instruction word
- dec_ready  input  1  decoder can accept this cycle
- to_dec  output  1  instruction valid at queue head
- to_dec_pc  output  32  PC of head instruction
- to_dec_inst  output  32  head instruction word

Behaviour:
- Reset (async, rst_in=1):
  - pc=RESET_PC; state=IDLE; head=tail=0; count=0.
  - mem_req=0, mem_addr=0, to_dec=0.
  - to_dec_pc and to_dec_inst read the queue head and carry no meaning while to_dec=0.
- All register updates are qualified by rdy_in=1 except reset.
- States:
  - IDLE: no fetch outstanding.
  - WAIT: fetch outstanding, result will be kept.
  - DROP: fetch outstanding, result will be discarded.
- IDLE:
  - If clear=0 and count < 2^IQ_WIDTH: next cycle mem_req=1, mem_addr=pc, state=WAIT.
  - If count = 2^IQ_WIDTH: stay IDLE.
- WAIT: mem_req and mem_addr held. On mem_done (with clear=0):
  - push {pc, mem_data} at tail; tail++ (wraps mod depth).
  - pc <= pc+4 (32-bit wrap).
  - mem_req <= 0; state=IDLE.
  - The next request issues the following cycle, so minimum spacing is 2 cycles per fetch.
- Only one fetch is ever outstanding. Because requests issue only when count < depth, a push never meets a full queue.
- Decoder side:
  - to_dec = (count != 0), driven combinationally from registered state.
  - to_dec_pc and to_dec_inst come from the head entry.
  - Pop occurs when to_dec && dec_ready: head++ (wraps).
  - dec_ready while empty is ignored.
- Same-cycle push and pop: count unchanged, both pointers advance.
- Clear (highest priority):
  - Same cycle: count=0 and head=tail=0 next cycle, so to_dec=0 the following cycle. Any pop this cycle is voided; any push this cycle is discarded.
  - pc <= clear_pc.
  - From IDLE: stay IDLE and suppress a new request this cycle; the fetch from clear_pc issues the next cycle.
  - From WAIT with mem_done=0: go to DROP; mem_req and mem_addr stay held (the memory protocol requires completion).
  - From WAIT with mem_done=1: data discarded; mem_req=0; go to IDLE.
  - In DROP: a further clear updates pc again and stays in DROP.
- DROP: on mem_done, discard the data, do not change pc, mem_req=0, go to IDLE.
- rdy_in=0 while mem_done pulses: the pulse is lost. Memory must not complete while rdy_in=0 (system contract).

Test Plan:
- Reset with RESET_PC=0; memory returns 0x00000013 after 3 cycles; dec_ready=1 -> mem_addr=0 then 4, 8; to_dec_pc sequence 0,4,8; each to_dec asserted the cycle after its mem_done.
- dec_ready=0 permanently -> exactly 4 fetches (addr 0,4,8,12); to_dec stays 1 with pc 0; mem_req stays 0 afterwards. Raise dec_ready for 1 cycle -> one pop, then one fetch at addr 16.
- clear with clear_pc=0x100 while WAIT on addr 8, mem_done 2 cycles later -> mem_req held until done; data dropped; next mem_addr=0x100; to_dec=0 until 0x100 returns; no pc 8 ever presented.
- clear coincident with mem_done and dec_ready -> neither push nor pop takes effect; count=0; next fetch at clear_pc.
- Two clears (0x200 then 0x300) while in DROP -> first fetch after drop is 0x300.
- rst_in asserted mid-WAIT -> outputs reset immediately (async); after release, fetch restarts at RESET_PC with an empty queue.
